// File: rtl/scmp_useq.sv
// scmp_useq - parametrised microcode sequencer for the SC/MP core.
// Drives a microcode address to an external combinational ROM, decodes the
// returned word into bus strobes and a datapath control field, and computes
// the next address (sequential, jump, branch, call/return, dispatch, wait).
// Optional feature macro: SCMP_USEQ_STACK_EN enables the return-address
// stack. Without it, CALL behaves as JUMP, RET as START, and sp/err read 0.
module scmp_useq #(
    parameter  int ADDR_W      = 8,
    parameter  int CTL_W       = 8,
    parameter  int COND_W      = 4,
    parameter  int STACK_DEPTH = 2,
    localparam int CSW         = $clog2(COND_W),
    localparam int SPW         = $clog2(STACK_DEPTH + 1),
    localparam int MCW         = CTL_W + 3 + 3 + 1 + CSW + ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mc_addr,
    input  logic [MCW-1:0]    mc_word,
    input  logic [COND_W-1:0] cond,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              bus_rdy,
    output logic [CTL_W-1:0]  ctl,
    output logic              bus_ADS_n,
    output logic              bus_RD_n,
    output logic              bus_WR_n,
    output logic [SPW-1:0]    sp,
    output logic              err
);

    typedef enum logic [2:0] {
        SEQ_START    = 3'b000,
        SEQ_NEXT     = 3'b001,
        SEQ_JUMP     = 3'b010,
        SEQ_BRANCH   = 3'b011,
        SEQ_CALL     = 3'b100,
        SEQ_RET      = 3'b101,
        SEQ_DISPATCH = 3'b110,
        SEQ_WAIT     = 3'b111
    } seq_e;

    // Field positions inside the microcode word, LSB first.
    localparam int POL_LSB = ADDR_W + CSW;
    localparam int SEQ_LSB = POL_LSB + 1;
    localparam int BUS_LSB = SEQ_LSB + 3;
    localparam int CTL_LSB = BUS_LSB + 3;

    logic [ADDR_W-1:0] mc_pc_q;
    logic [ADDR_W-1:0] mc_pc_d;
    logic [ADDR_W-1:0] inc_s;
    logic [ADDR_W-1:0] target_s;
    logic [CSW-1:0]    sel_s;
    logic              pol_s;
    seq_e              seq_s;
    logic [2:0]        bus_s;
    logic [CTL_W-1:0]  ctl_field_s;

    assign target_s    = mc_word[ADDR_W-1:0];
    assign sel_s       = mc_word[ADDR_W +: CSW];
    assign pol_s       = mc_word[POL_LSB];
    assign seq_s       = seq_e'(mc_word[SEQ_LSB +: 3]);
    assign bus_s       = mc_word[BUS_LSB +: 3];
    assign ctl_field_s = mc_word[CTL_LSB +: CTL_W];
    assign inc_s       = mc_pc_q + ADDR_W'(1);
    assign mc_addr     = mc_pc_q;

`ifdef SCMP_USEQ_STACK_EN
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic [SPW-1:0]    sp_q;
    logic [SPW-1:0]    sp_d;
    logic              err_q;
    logic              err_d;
    logic [ADDR_W-1:0] top_s;
    logic              full_s;
    logic              empty_s;

    assign full_s  = (sp_q == SPW'(STACK_DEPTH));
    assign empty_s = (sp_q == SPW'(0));
    assign sp      = sp_q;
    assign err     = err_q;

    // Top-of-stack read: the entry just below the occupancy pointer.
    always_comb begin
        top_s = {ADDR_W{1'b0}};
        for (int i = 0; i < STACK_DEPTH; i++) begin
            top_s = (sp_q == SPW'(i + 1)) ? stack_q[i] : top_s;
        end
    end
`else
    assign sp  = {SPW{1'b0}};
    assign err = 1'b0;
`endif

    // Strobes and control field straight from the word, held inactive in reset.
    always_comb begin
        ctl       = {CTL_W{1'b0}};
        bus_ADS_n = 1'b1;
        bus_RD_n  = 1'b1;
        bus_WR_n  = 1'b1;
        if (rst_n) begin
            ctl       = ctl_field_s;
            bus_ADS_n = ~bus_s[2];
            bus_RD_n  = ~bus_s[1];
            bus_WR_n  = ~bus_s[0];
        end else begin
            ctl       = {CTL_W{1'b0}};
        end
    end

    // Next-address selection plus stack push/pop bookkeeping.
    always_comb begin
        mc_pc_d = inc_s;
`ifdef SCMP_USEQ_STACK_EN
        sp_d    = sp_q;
        err_d   = err_q;
        stack_d = stack_q;
`endif
        case (seq_s)
            SEQ_START:    mc_pc_d = {ADDR_W{1'b0}};
            SEQ_NEXT:     mc_pc_d = inc_s;
            SEQ_JUMP:     mc_pc_d = target_s;
            SEQ_BRANCH:   mc_pc_d = (cond[sel_s] ^ pol_s) ? target_s : inc_s;
            SEQ_CALL: begin
                mc_pc_d = target_s;
`ifdef SCMP_USEQ_STACK_EN
                // A full stack still takes the jump; the return address is lost.
                if (full_s) begin
                    err_d = 1'b1;
                end else begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        stack_d[i] = (sp_q == SPW'(i)) ? inc_s : stack_q[i];
                    end
                    sp_d = sp_q + SPW'(1);
                end
`endif
            end
            SEQ_RET: begin
`ifdef SCMP_USEQ_STACK_EN
                if (empty_s) begin
                    mc_pc_d = {ADDR_W{1'b0}};
                    err_d   = 1'b1;
                end else begin
                    mc_pc_d = top_s;
                    sp_d    = sp_q - SPW'(1);
                end
`else
                mc_pc_d = {ADDR_W{1'b0}};
`endif
            end
            SEQ_DISPATCH: mc_pc_d = disp_addr;
            SEQ_WAIT:     mc_pc_d = bus_rdy ? inc_s : mc_pc_q;
            default:      mc_pc_d = {ADDR_W{1'b0}};
        endcase
    end

    // Sequencer state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_pc_q <= {ADDR_W{1'b0}};
`ifdef SCMP_USEQ_STACK_EN
            sp_q    <= {SPW{1'b0}};
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= {ADDR_W{1'b0}};
            end
`endif
        end else begin
            mc_pc_q <= mc_pc_d;
`ifdef SCMP_USEQ_STACK_EN
            sp_q    <= sp_d;
            err_q   <= err_d;
            stack_q <= stack_d;
`endif
        end
    end

endmodule

// File: tb/tb_scmp_useq.sv
// tb_scmp_useq - directed bench for scmp_useq with a behavioural ROM and a
// scoreboard of expected per-cycle outputs.
module tb_scmp_useq;

    localparam int ADDR_W      = 8;
    localparam int CTL_W       = 8;
    localparam int COND_W      = 4;
    localparam int STACK_DEPTH = 2;
    localparam int MCW         = 25;

    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_NEXT  = 3'd1;
    localparam logic [2:0] S_JUMP  = 3'd2;
    localparam logic [2:0] S_BR    = 3'd3;
    localparam logic [2:0] S_CALL  = 3'd4;
    localparam logic [2:0] S_RET   = 3'd5;
    localparam logic [2:0] S_DISP  = 3'd6;
    localparam logic [2:0] S_WAIT  = 3'd7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [MCW-1:0]    mc_word;
    logic [ADDR_W-1:0] mc_addr;
    logic [COND_W-1:0] cond = 4'b0000;
    logic [ADDR_W-1:0] disp_addr = 8'h00;
    logic              bus_rdy = 1'b0;
    logic [CTL_W-1:0]  ctl;
    logic              ads_n, rd_n, wr_n;
    logic [1:0]        sp;
    logic              err;

    logic [MCW-1:0] rom [256];
    assign mc_word = rom[mc_addr];

    always #5 clk = ~clk;

    scmp_useq #(
        .ADDR_W(ADDR_W), .CTL_W(CTL_W), .COND_W(COND_W), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mc_addr(mc_addr), .mc_word(mc_word),
        .cond(cond), .disp_addr(disp_addr), .bus_rdy(bus_rdy), .ctl(ctl),
        .bus_ADS_n(ads_n), .bus_RD_n(rd_n), .bus_WR_n(wr_n), .sp(sp), .err(err)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [2:0] strb_n;
        logic [7:0] ctl;
        logic [1:0] sp;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [MCW-1:0] mk(input logic [2:0] seq, input logic [7:0] tgt,
                                          input logic [1:0] sel, input logic pol,
                                          input logic [2:0] bus, input logic [7:0] c);
        return {c, bus, seq, pol, sel, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_now(input string tag, input exp_t e);
        check({tag, ".addr"}, 32'(mc_addr), 32'(e.addr));
        check({tag, ".strb"}, 32'({ads_n, rd_n, wr_n}), 32'(e.strb_n));
        check({tag, ".ctl"},  32'(ctl), 32'(e.ctl));
        check({tag, ".sp"},   32'(sp), 32'(e.sp));
        check({tag, ".err"},  32'(err), 32'(e.err));
    endtask

    task automatic push(input logic [7:0] a, input logic [2:0] s, input logic [7:0] c,
                        input logic [1:0] p, input logic e);
        exp_t x;
        x.addr = a; x.strb_n = s; x.ctl = c; x.sp = p; x.err = e;
        sb_q.push_back(x);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL %s scoreboard empty observed_addr=%0h expected=entry", tag, mc_addr);
            end else begin
                expect_now(tag, sb_q.pop_front());
            end
        end
    endtask

    // Assert reset away from the edge, check async reset state, clear the ROM.
    task automatic enter_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check({tag, ".rst_addr"}, 32'(mc_addr), 32'h0);
        check({tag, ".rst_sp"},   32'(sp), 32'h0);
        check({tag, ".rst_err"},  32'(err), 32'h0);
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    // With the new ROM in place, confirm outputs are masked, then release.
    task automatic release_reset(input string tag);
        #1;
        check({tag, ".rst_strb"}, 32'({ads_n, rd_n, wr_n}), 32'h7);
        check({tag, ".rst_ctl"},  32'(ctl), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;

        // Fetch loop with strobes and per-address control fields.
        enter_reset("fetch");
        rom[0] = mk(S_NEXT, 8'h00, 2'd0, 1'b0, 3'b001, 8'hA5);
        rom[1] = mk(S_NEXT, 8'h00, 2'd0, 1'b0, 3'b100, 8'h3C);
        rom[2] = mk(S_NEXT, 8'h00, 2'd0, 1'b0, 3'b010, 8'h81);
        rom[3] = mk(S_JUMP, 8'h00, 2'd0, 1'b0, 3'b000, 8'h7E);
        release_reset("fetch");
        expect_now("fetch0", {8'h00, 3'b110, 8'hA5, 2'd0, 1'b0});
        push(8'h01, 3'b011, 8'h3C, 2'd0, 1'b0);
        push(8'h02, 3'b101, 8'h81, 2'd0, 1'b0);
        push(8'h03, 3'b111, 8'h7E, 2'd0, 1'b0);
        push(8'h00, 3'b110, 8'hA5, 2'd0, 1'b0);
        push(8'h01, 3'b011, 8'h3C, 2'd0, 1'b0);
        run("fetch", 5);

        // Branch on cond[2] with both polarities, other flags set opposite.
        for (int k = 0; k < 4; k++) begin
            logic       pol_b;
            logic       hit_b;
            logic [7:0] nxt;
            pol_b = (k >= 2);
            hit_b = (k % 2 == 1);
            nxt   = (hit_b ^ pol_b) ? 8'h40 : 8'h06;
            enter_reset("branch");
            rom[0] = mk(S_JUMP, 8'h05, 2'd0, 1'b0, 3'b000, 8'h00);
            rom[5] = mk(S_BR,   8'h40, 2'd2, pol_b, 3'b000, 8'h00);
            cond   = hit_b ? 4'b0100 : 4'b1011;
            release_reset("branch");
            push(8'h05, 3'b111, 8'h00, 2'd0, 1'b0);
            push(nxt,   3'b111, 8'h00, 2'd0, 1'b0);
            run("branch", 2);
        end
        cond = 4'b0000;

        // Wait state: ready low for three samples, then high.
        enter_reset("wait");
        rom[0] = mk(S_NEXT,  8'h00, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[1] = mk(S_WAIT,  8'h00, 2'd0, 1'b0, 3'b010, 8'h5A);
        rom[2] = mk(S_START, 8'h00, 2'd0, 1'b0, 3'b000, 8'h00);
        bus_rdy = 1'b0;
        release_reset("wait");
        for (int i = 0; i < 4; i++) push(8'h01, 3'b101, 8'h5A, 2'd0, 1'b0);
        push(8'h02, 3'b111, 8'h00, 2'd0, 1'b0);
        run("wait", 4);
        bus_rdy = 1'b1;
        run("wait_rdy", 1);

        // Reset in the middle of a wait releases the strobe at once.
        enter_reset("waitrst");
        rom[0] = mk(S_NEXT, 8'h00, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[1] = mk(S_WAIT, 8'h00, 2'd0, 1'b0, 3'b010, 8'h5A);
        bus_rdy = 1'b0;
        release_reset("waitrst");
        push(8'h01, 3'b101, 8'h5A, 2'd0, 1'b0);
        push(8'h01, 3'b101, 8'h5A, 2'd0, 1'b0);
        run("waitrst", 2);
        rst_n = 1'b0;
        #1;
        check("waitrst.rd_n", 32'(rd_n), 32'h1);
        check("waitrst.addr", 32'(mc_addr), 32'h0);
        check("waitrst.ctl",  32'(ctl), 32'h0);

        // Dispatch then address wrap.
        enter_reset("disp");
        rom[8'h00] = mk(S_DISP, 8'h00, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h9C] = mk(S_JUMP, 8'hFF, 2'd0, 1'b0, 3'b000, 8'h11);
        rom[8'hFF] = mk(S_NEXT, 8'h00, 2'd0, 1'b0, 3'b000, 8'h22);
        disp_addr = 8'h9C;
        release_reset("disp");
        push(8'h9C, 3'b111, 8'h11, 2'd0, 1'b0);
        push(8'hFF, 3'b111, 8'h22, 2'd0, 1'b0);
        push(8'h00, 3'b111, 8'h00, 2'd0, 1'b0);
        run("disp", 3);

`ifdef SCMP_USEQ_STACK_EN
        // Nested calls, returns, then overflow that must keep stack contents.
        enter_reset("stack");
        rom[8'h00] = mk(S_JUMP,  8'h10, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h10] = mk(S_CALL,  8'h20, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h20] = mk(S_CALL,  8'h30, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h30] = mk(S_RET,   8'h00, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h21] = mk(S_RET,   8'h00, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h11] = mk(S_CALL,  8'h50, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h50] = mk(S_CALL,  8'h60, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h60] = mk(S_CALL,  8'h70, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h70] = mk(S_RET,   8'h00, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h51] = mk(S_START, 8'h00, 2'd0, 1'b0, 3'b000, 8'h00);
        release_reset("stack");
        push(8'h10, 3'b111, 8'h00, 2'd0, 1'b0);
        push(8'h20, 3'b111, 8'h00, 2'd1, 1'b0);
        push(8'h30, 3'b111, 8'h00, 2'd2, 1'b0);
        push(8'h21, 3'b111, 8'h00, 2'd1, 1'b0);
        push(8'h11, 3'b111, 8'h00, 2'd0, 1'b0);
        push(8'h50, 3'b111, 8'h00, 2'd1, 1'b0);
        push(8'h60, 3'b111, 8'h00, 2'd2, 1'b0);
        push(8'h70, 3'b111, 8'h00, 2'd2, 1'b1);
        push(8'h51, 3'b111, 8'h00, 2'd1, 1'b1);
        push(8'h00, 3'b111, 8'h00, 2'd1, 1'b1);
        run("stack", 10);

        // Underflow: RET on empty stack goes to 0 and err sticks.
        enter_reset("under");
        rom[0] = mk(S_JUMP, 8'h07, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[7] = mk(S_RET,  8'h00, 2'd0, 1'b0, 3'b000, 8'h00);
        release_reset("under");
        push(8'h07, 3'b111, 8'h00, 2'd0, 1'b0);
        push(8'h00, 3'b111, 8'h00, 2'd0, 1'b1);
        push(8'h07, 3'b111, 8'h00, 2'd0, 1'b1);
        push(8'h00, 3'b111, 8'h00, 2'd0, 1'b1);
        run("under", 4);
`else
        // Without the stack: CALL is a jump, RET restarts, sp/err stay 0.
        enter_reset("nostack");
        rom[8'h00] = mk(S_CALL, 8'h20, 2'd0, 1'b0, 3'b000, 8'h00);
        rom[8'h20] = mk(S_RET,  8'h00, 2'd0, 1'b0, 3'b000, 8'h00);
        release_reset("nostack");
        push(8'h20, 3'b111, 8'h00, 2'd0, 1'b0);
        push(8'h00, 3'b111, 8'h00, 2'd0, 1'b0);
        push(8'h20, 3'b111, 8'h00, 2'd0, 1'b0);
        run("nostack", 3);
`endif

        // Final reset clears err; scoreboard must be drained.
        enter_reset("final");
        check("final.sb_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scmp_useq.md
Name: scmp_useq

Overview:
Parametrised microcode sequencer for the SC/MP core. It is the successor to the fixed fetch-loop sequencer.
- Drives a microcode address to an external combinational microcode ROM and decodes the returned word.
- Supports sequential, jump, conditional branch, call/return, opcode dispatch and bus wait-state operations.
- Generates the active-low bus strobes and a generic control field for the datapath.

Parameters:
ADDR_W, 8, microcode address width (ROM depth 2**ADDR_W)
CTL_W, 8, width of datapath control field passed through from the microcode word
COND_W, 4, number of condition inputs (power of two, >=2); CSW = clog2(COND_W)
STACK_DEPTH, 2, return-address stack entries (>=1)
MCW, CTL_W+3+3+1+CSW+ADDR_W, microcode word width (derived, do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mc_addr  out  ADDR_W  current microcode address (registered mc_pc)
mc_word  in  MCW  microcode word at mc_addr, valid same cycle
cond  in  COND_W  datapath condition flags
disp_addr  in  ADDR_W  dispatch target from opcode decode
bus_rdy  in  1  bus ready; high ends a WAIT
ctl  out  CTL_W  datapath control field of current word
bus_ADS_n  out  1  address strobe, active low
bus_RD_n  out  1  read strobe, active low
bus_WR_n  out  1  write strobe, active low
sp  out  clog2(STACK_DEPTH+1)  stack occupancy
err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Word layout, LSB first:
  - target[ADDR_W]
  - sel[CSW]
  - pol[1]
  - seq[3]
  - bus[3] = {ADS,RD,WR}, active high
  - ctl[CTL_W]
- Outputs are combinational from mc_word: ctl = field; {bus_ADS_n,bus_RD_n,bus_WR_n} = ~bus.
- While rst_n low: all bus strobes forced high, ctl forced 0.
- Reset state: mc_pc=0, sp=0, stack contents 0, err=0.
- mc_pc updates every clock; inc = mc_pc+1 mod 2**ADDR_W (wraps to 0).
- seq encoding, giving the next mc_pc:
  - 000 START: 0
  - 001 NEXT: inc
  - 010 JUMP: target
  - 011 BRANCH: (cond[sel]^pol) ? target : inc
  - 100 CALL: push inc; target
  - 101 RET: pop
  - 110 DISPATCH: disp_addr
  - 111 WAIT: bus_rdy ? inc : mc_pc. The word is held, so the strobes stay asserted for every wait cycle. Minimum one cycle.
- Stack is LIFO; one push or pop per cycle at most, determined by seq.
- CALL with sp==STACK_DEPTH:
  - jump still taken, return address discarded, stack unchanged, err<=1.
- RET with sp==0:
  - next mc_pc=0, err<=1.
- err clears only on reset.
- Reset asserted mid-operation (including mid-WAIT): immediate return to the reset state, strobes deasserted asynchronously.

Optional Feature:
Macro SCMP_USEQ_STACK_EN.
- Defined: CALL/RET behave as above.
- Undefined:
  - no stack storage
  - CALL acts as JUMP
  - RET acts as START
  - sp tied 0, err tied 0

Test Plan:
- Fetch loop: ROM 0:NEXT, 1:NEXT bus=ADS, 2:NEXT bus=RD, 3:JUMP target 0 -> mc_addr 0,1,2,3,0...; bus_ADS_n low only at addr1, bus_RD_n low only at addr2.
- Branch: addr 5 BRANCH sel=2 pol=0 target 0x40. cond=4'b0100 -> next 0x40; cond=0 -> next 6. pol=1 inverts both results.
- Call/return (STACK_EN, depth 2): calls at 0x10 ->0x20 and 0x20 ->0x30, then RET, RET -> mc_addr 0x21 then 0x11; sp 1,2,1,0; err=0. A third nested CALL -> target taken, err=1, sp stays 2.
- Underflow: RET with sp=0 at addr 7 -> next 0, err=1 and stays 1 until rst_n low.
- Wait states: WAIT with bus=RD; bus_rdy low 3 cycles then high -> mc_addr held 4 cycles, bus_RD_n low all 4, then inc. Assert rst_n low during the wait -> bus_RD_n high immediately, mc_addr 0.
- Dispatch/wrap: DISPATCH with disp_addr 0x9C -> next 0x9C; NEXT at 0xFF -> next 0x00. Without SCMP_USEQ_STACK_EN: CALL 0x20 -> 0x20, RET -> 0, sp=0, err=0.
